shift_serializer: RTL

- Parallel-to-serial transmitter: the producer end of the shift_register serial interface.
- Accepts a WIDTH-bit word over a valid/ready handshake, then emits one bit per enabled cycle on serial_o.
- Drives funct_o (LEFT/RIGHT) so that a downstream shift_register of the same WIDTH holds the original word once the frame completes.
- Signals frame completion with a one-cycle done_o pulse.

---
 rtl/shift_serializer_pkg.sv | 20 ++
 rtl/shift_serializer.sv | 102 ++++++++++
 2 files changed

// File: rtl/shift_serializer_pkg.sv
// Shared types for the shift-register serial interface: the downstream
// command encoding and the serializer's frame state.
package shift_pkg;

  // Command understood by the downstream shift_register on funct_i
  typedef enum logic [1:0] {
    NA    = 2'd0,
    LOAD  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } funct_t;

  // Frame state of the serializer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter feeding a downstream shift_register.
// A word is taken on a valid/ready handshake, then one bit leaves per
// enabled cycle while funct_o tells the receiver which way to shift, so the
// receiver holds the original word during the single DONE cycle.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] word_i,
  input  logic             msb_first_i,
  input  logic             en_i,
  output logic             serial_o,
  output funct_t           funct_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shadow;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lastBit;

  assign w_lastBit = (r_cnt == LAST_IDX);

  // Frame sequencing: capture in IDLE, shift on enabled cycles, one DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_shadow <= word_i;
            r_dir    <= msb_first_i;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (en_i) begin
            if (r_dir) begin
              r_shadow <= r_shadow << 1;
            end else begin
              r_shadow <= r_shadow >> 1;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastBit) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state and en_i only, never from valid_i
  always_comb begin
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    funct_o  = NA;
    serial_o = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
      end
      SHIFT: begin
        busy_o   = 1'b1;
        serial_o = r_dir ? r_shadow[WIDTH-1] : r_shadow[0];
        if (en_i) begin
          funct_o = r_dir ? LEFT : RIGHT;
        end
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

endmodule
